// File: rtl/status_flag_unit.sv
// NZCV status register with EX-to-ID flag bypass, saved status for
// exceptions, and a visibility-delay stall path when bypass is off.
module status_flag_unit #(
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned VIS_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic       ex_exec,
  input  logic [3:0] ex_flags,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       exc_save,
  input  logic       exc_restore,
  output logic [3:0] status_out,
  output logic [3:0] spsr_out,
  output logic       flag_stall,
  output logic       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] LAT = 3'(VIS_LAT);
  localparam logic [3:0] COND_AL = 4'b1110;

  logic [3:0] status_q, status_d;
  logic [3:0] spsr_q, spsr_d;
  state_t     state_q;
  logic [2:0] cnt_q;
  logic       busy_q;

  logic upd_raw;
  logic upd;
  logic rest;
  logic save;

  assign upd_raw = ex_valid & ex_s & ex_exec;
  assign upd     = upd_raw & ~freeze;
  assign rest    = exc_restore & ~freeze;
  assign save    = exc_save & ~freeze;

  // Next architectural and saved status; restore beats an ALU write
  always_comb begin
    status_d = status_q;
    spsr_d   = spsr_q;
    if (rest) begin
      status_d = spsr_q;
    end else if (upd) begin
      status_d = ex_flags;
    end
    if (save) begin
      spsr_d = status_q;
    end
  end

  // Status and SPSR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 4'd0;
      spsr_q   <= 4'd0;
    end else begin
      status_q <= status_d;
      spsr_q   <= spsr_d;
    end
  end

  // Visibility FSM: counts unfrozen cycles until a flag write is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else if (!FWD_EN && !freeze) begin
      if (upd || rest) begin
        state_q <= S_WAIT;
        cnt_q   <= LAT;
        busy_q  <= 1'b1;
      end else if (state_q == S_WAIT) begin
        if (cnt_q <= 3'd1) begin
          state_q <= S_IDLE;
          cnt_q   <= 3'd0;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
    end
  end

  // Bypass selects in-flight flags only when no restore overrides them
  always_comb begin
    status_out = status_q;
    if (FWD_EN && upd && !rest) begin
      status_out = ex_flags;
    end
  end

  assign spsr_out = spsr_q;
  assign busy     = busy_q;

  assign flag_stall = !FWD_EN && id_valid &&
                      (id_cond != COND_AL) &&
                      (upd_raw || state_q == S_WAIT);

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: one bypass instance and one stall
// instance (VIS_LAT=2) driven in parallel and checked against a model.
module tb_status_flag_unit;

  localparam int LAT = 2;

  logic       clk;
  logic       rst, fz, ev, es, ex, iv, sv, rs;
  logic [3:0] fl, ic;

  logic [3:0] f_st, f_sp, s_st, s_sp;
  logic       f_stall, f_busy, s_stall, s_busy;

  int errors = 0;
  int checks = 0;

  // model state
  logic [3:0] m_status, m_spsr;
  int         m_ucnt;
  int         m_ev;
  bit         m_evv;

  status_flag_unit #(.FWD_EN(1'b1), .VIS_LAT(1)) dut_f (
    .clk(clk), .rst(rst), .freeze(fz),
    .ex_valid(ev), .ex_s(es), .ex_exec(ex), .ex_flags(fl),
    .id_valid(iv), .id_cond(ic),
    .exc_save(sv), .exc_restore(rs),
    .status_out(f_st), .spsr_out(f_sp),
    .flag_stall(f_stall), .busy(f_busy)
  );

  status_flag_unit #(.FWD_EN(1'b0), .VIS_LAT(LAT)) dut_s (
    .clk(clk), .rst(rst), .freeze(fz),
    .ex_valid(ev), .ex_s(es), .ex_exec(ex), .ex_flags(fl),
    .id_valid(iv), .id_cond(ic),
    .exc_save(sv), .exc_restore(rs),
    .status_out(s_st), .spsr_out(s_sp),
    .flag_stall(s_stall), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_upd();
    return ev & es & ex & ~fz;
  endfunction

  function automatic logic [3:0] m_fwd();
    return (m_upd() && !rs) ? fl : m_status;
  endfunction

  // a write is invisible for LAT unfrozen cycles after its edge
  function automatic bit m_busy();
    return m_evv && (m_ucnt - m_ev < LAT);
  endfunction

  function automatic bit m_stall();
    return iv && (ic != 4'b1110) && ((ev & es & ex) || m_busy());
  endfunction

  task automatic tick();
    logic [3:0] ns;
    @(posedge clk);
    if (rst) begin
      m_status = 4'd0;
      m_spsr   = 4'd0;
      m_evv    = 1'b0;
    end else if (!fz) begin
      ns = rs ? m_spsr : (m_upd() ? fl : m_status);
      if (sv) m_spsr = m_status;
      m_status = ns;
      m_ucnt++;
      if (m_upd() || rs) begin
        m_ev  = m_ucnt;
        m_evv = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; fz = 0; ev = 0; es = 0; ex = 0; fl = 0;
    iv = 0; ic = 0; sv = 0; rs = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (f_st !== 4'b0000) begin
      errors++;
      $display("FAIL reset_f_status got=%b exp=0000", f_st);
    end
    checks++;
    if (s_st !== 4'b0000 || s_sp !== 4'b0000) begin
      errors++;
      $display("FAIL reset_s_regs got=%b/%b exp=0000/0000", s_st, s_sp);
    end
    checks++;
    if (s_stall !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b/%b exp=0/0", s_stall, s_busy);
    end
    tick();
  endtask

  task automatic test_forward();
    idle();
    ev = 1; es = 1; ex = 1; fl = 4'b0100;
    @(negedge clk);
    checks++;
    if (f_st !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_same_cycle got=%b exp=0100", f_st);
    end
    checks++;
    if (s_st !== 4'b0000) begin
      errors++;
      $display("FAIL nofwd_same_cycle got=%b exp=0000", s_st);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (f_st !== 4'b0100 || s_st !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_after_edge got=%b/%b exp=0100", f_st, s_st);
    end
    repeat (4) tick();
  endtask

  task automatic test_stall();
    bit exp_s [4];
    logic [3:0] conds [2];
    exp_s = '{1'b1, 1'b1, 1'b1, 1'b0};
    conds = '{4'b0000, 4'b1110};
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        idle();
        iv = 1; ic = conds[c];
        if (k == 0) begin
          ev = 1; es = 1; ex = 1; fl = 4'b1001;
        end
        @(negedge clk);
        checks++;
        if (s_stall !== (exp_s[k] & (c == 0))) begin
          errors++;
          $display("FAIL stall c=%0d k=%0d got=%b exp=%b",
                   c, k, s_stall, exp_s[k] & (c == 0));
        end
        if (k > 0) begin
          checks++;
          if (s_st !== 4'b1001) begin
            errors++;
            $display("FAIL stall_status k=%0d got=%b exp=1001", k, s_st);
          end
        end
        tick();
      end
      idle();
      repeat (3) tick();
    end
  endtask

  task automatic test_gating();
    logic [3:0] st0, sp0;
    idle();
    st0 = m_status;
    ev = 1; es = 1; ex = 0; fl = 4'b1111;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (s_st !== st0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_exec got=%b/%b exp=%b/0", s_st, s_busy, st0);
    end
    ev = 1; es = 1; ex = 1; fl = 4'b0110;
    tick();
    st0 = m_status;
    sp0 = m_spsr;
    idle();
    fz = 1; ev = 1; es = 1; ex = 1; fl = 4'b1010; sv = 1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (s_st !== st0 || s_sp !== sp0 || f_st !== st0) begin
      errors++;
      $display("FAIL freeze_regs got=%b/%b exp=%b/%b", s_st, s_sp, st0, sp0);
    end
    idle();
    tick();
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b1) begin
      errors++;
      $display("FAIL freeze_counter got=%b exp=1", s_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL freeze_count_end got=%b exp=0", s_busy);
    end
  endtask

  task automatic test_exc();
    idle();
    ev = 1; es = 1; ex = 1; fl = 4'b0010;
    tick();
    fl = 4'b1100; sv = 1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (s_sp !== 4'b0010 || s_st !== 4'b1100) begin
      errors++;
      $display("FAIL exc_save got=%b/%b exp=0010/1100", s_sp, s_st);
    end
    repeat (3) tick();
    rs = 1;
    @(negedge clk);
    checks++;
    if (f_st !== 4'b1100) begin
      errors++;
      $display("FAIL restore_no_bypass got=%b exp=1100", f_st);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (s_st !== 4'b0010 || f_st !== 4'b0010 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL exc_restore got=%b/%b busy=%b exp=0010/0010 busy=1",
               s_st, f_st, s_busy);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    ev = 1; es = 1; ex = 1; fl = 4'b0111;
    tick();
    idle();
    tick();
    iv = 1;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_stall !== 1'b0 || s_st !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_wait got=%b/%b/%b exp=0/0/0000",
               s_busy, s_stall, s_st);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      fz  = ($urandom_range(0, 7) == 0);
      ev  = ($urandom_range(0, 3) != 0);
      es  = $urandom_range(0, 1);
      ex  = ($urandom_range(0, 3) != 0);
      fl  = 4'($urandom);
      iv  = $urandom_range(0, 1);
      ic  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      sv  = ($urandom_range(0, 9) == 0);
      rs  = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      checks++;
      if (f_st !== m_fwd() || f_sp !== m_spsr) begin
        errors++;
        $display("FAIL rnd_f n=%0d got=%b/%b exp=%b/%b",
                 n, f_st, f_sp, m_fwd(), m_spsr);
      end
      checks++;
      if (f_stall !== 1'b0 || f_busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_f_stall n=%0d got=%b/%b exp=0/0",
                 n, f_stall, f_busy);
      end
      checks++;
      if (s_st !== m_status || s_sp !== m_spsr) begin
        errors++;
        $display("FAIL rnd_s n=%0d got=%b/%b exp=%b/%b",
                 n, s_st, s_sp, m_status, m_spsr);
      end
      checks++;
      if (s_busy !== m_busy() || s_stall !== m_stall()) begin
        errors++;
        $display("FAIL rnd_s_stall n=%0d got=%b/%b exp=%b/%b",
                 n, s_busy, s_stall, m_busy(), m_stall());
      end
      tick();
    end
  endtask

  initial begin
    m_status = 0;
    m_spsr   = 0;
    m_ucnt   = 0;
    m_ev     = 0;
    m_evv    = 0;
    idle();
    test_reset();
    test_forward();
    test_stall();
    test_gating();
    test_exc();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
